plic_irq_ctrl: RTL

// - Claim/complete sequencer between the PLIC source arbiter and the core trap unit.
// - Qualifies the PLIC winner against a priority threshold.
// - Waits for the PLIC vector/arg pipeline to settle, then issues a stable req/ack interrupt request.
// - Masks the claimed source back to the PLIC until the core signals completion (mret).

---
 rtl/plic_pkg.sv | 28 ++
 rtl/plic_nest_stack.sv | 57 +++++
 rtl/plic_irq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/plic_pkg.sv
// Shared types for the PLIC claim/complete controller.
// The context struct carries a fixed-width id field so it can be shared by
// every NUM_SRC configuration; users zero-extend / truncate to their ID_W.
package plic_pkg;

    localparam int PLIC_PRI_W    = 8;
    localparam int PLIC_CTX_ID_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        REQ    = 2'd2,
        ACTIVE = 2'd3
    } plic_ctrl_state_e;

    typedef struct packed {
        logic [PLIC_CTX_ID_W-1:0] id;
        logic [PLIC_PRI_W-1:0]    pri;
    } plic_ctx_t;

    function automatic logic [PLIC_PRI_W-1:0] plic_pri_max(
        input logic [PLIC_PRI_W-1:0] a,
        input logic [PLIC_PRI_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/plic_nest_stack.sv
// LIFO of preempted handler contexts for nested interrupt preemption.
// Only instantiated when PLIC_IRQ_PREEMPT_EN is defined.
// Push and pop are never requested in the same cycle by the controller;
// push wins if they ever are.
module plic_nest_stack
    import plic_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int DW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  plic_ctx_t     push_ctx,
    output plic_ctx_t     top_ctx,
    output logic [DW-1:0] depth
);

    plic_ctx_t      mem [DEPTH];
    logic [DW-1:0]  depth_m1;
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;
    logic           full;
    logic           empty;

    assign full     = (depth == DW'(DEPTH));
    assign empty    = (depth == '0);
    assign depth_m1 = depth - DW'(1);
    assign wr_idx   = depth[AW-1:0];
    assign rd_idx   = depth_m1[AW-1:0];

    // Most recently pushed context, or zero when nothing is stacked
    always_comb begin
        top_ctx = '0;
        if (!empty) begin
            top_ctx = mem[rd_idx];
        end
    end

    // Stack storage and occupancy; full pushes and empty pops are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[wr_idx] <= push_ctx;
            depth       <= depth + DW'(1);
        end else if (pop && !empty) begin
            depth <= depth_m1;
        end
    end

endmodule

// File: rtl/plic_irq_ctrl.sv
// Claim/complete sequencer between the PLIC arbiter and the core trap unit.
// A qualified winner is held through a settle window (the PLIC vector and
// argument lag the id), then offered to the core as a stable req/ack
// request; the claimed source is masked back to the PLIC until mret.
// Optional nested preemption is enabled by defining PLIC_IRQ_PREEMPT_EN.
module plic_irq_ctrl
    import plic_pkg::*;
#(
    parameter  int NUM_SRC    = 32,
    parameter  int SETTLE_CYC = 2,
    parameter  int NEST_DEPTH = 2,
    localparam int ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  plic_valid_i,
    input  logic [ID_W-1:0]       plic_id_i,
    input  logic [PLIC_PRI_W-1:0] plic_pri_i,
    input  logic [31:0]           plic_mvec_i,
    input  logic [31:0]           plic_marg_i,
    input  logic                  thr_we_i,
    input  logic [PLIC_PRI_W-1:0] thr_wdata_i,
    output logic [PLIC_PRI_W-1:0] thr_o,
    output logic                  irq_req_o,
    output logic [ID_W-1:0]       irq_id_o,
    output logic [31:0]           irq_vec_o,
    output logic [31:0]           irq_arg_o,
    input  logic                  irq_ack_i,
    input  logic                  irq_done_i,
    output logic [NUM_SRC-1:0]    claim_mask_o,
    output logic                  active_o
);

    localparam int              CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    if (SETTLE_CYC < 1) begin : g_settle_check
        $error("plic_irq_ctrl: SETTLE_CYC must be at least 1");
    end
    if (NEST_DEPTH < 1) begin : g_nest_check
        $error("plic_irq_ctrl: NEST_DEPTH must be at least 1");
    end

    plic_ctrl_state_e       state;
    logic [ID_W-1:0]        lat_id;
    logic [CNT_W-1:0]       cnt;
    logic [PLIC_PRI_W-1:0]  eff_thr;
    logic                   mask_hit;
    logic                   qualify;
    logic                   settle_abort;
    logic [NUM_SRC-1:0]     lat_onehot;

    assign mask_hit     = claim_mask_o[plic_id_i];
    assign qualify      = plic_valid_i && (plic_pri_i > eff_thr) && !mask_hit;
    assign settle_abort = !plic_valid_i || (plic_id_i != lat_id);
    assign lat_onehot   = NUM_SRC'(1) << lat_id;

`ifdef PLIC_IRQ_PREEMPT_EN
    localparam int NDW = $clog2(NEST_DEPTH + 1);

    logic [PLIC_PRI_W-1:0]  lat_pri;
    logic                   nest_push;
    logic                   nest_pop;
    plic_ctx_t              nest_push_ctx;
    plic_ctx_t              nest_top_ctx;
    logic [NDW-1:0]         nest_depth;
    logic                   nest_full;
    logic                   nest_empty;

    assign nest_full     = (nest_depth == NDW'(NEST_DEPTH));
    assign nest_empty    = (nest_depth == '0);
    assign nest_push_ctx = '{id: PLIC_CTX_ID_W'(lat_id), pri: lat_pri};

    // While a handler runs, a winner must beat both the threshold and the running priority
    always_comb begin
        eff_thr = thr_o;
        if (state == ACTIVE) begin
            eff_thr = plic_pri_max(thr_o, lat_pri);
        end
    end

    // Stack the running context on preemption; restore on completion or a failed preempt
    always_comb begin
        nest_push = 1'b0;
        nest_pop  = 1'b0;
        case (state)
            ACTIVE: begin
                if (irq_done_i) begin
                    nest_pop = !nest_empty;
                end else if (qualify && !nest_full) begin
                    nest_push = 1'b1;
                end
            end
            SETTLE: begin
                nest_pop = settle_abort && !nest_empty;
            end
            default: begin
                nest_push = 1'b0;
                nest_pop  = 1'b0;
            end
        endcase
    end

    plic_nest_stack #(
        .DEPTH (NEST_DEPTH)
    ) u_nest_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (nest_push),
        .pop      (nest_pop),
        .push_ctx (nest_push_ctx),
        .top_ctx  (nest_top_ctx),
        .depth    (nest_depth)
    );
`else
    assign eff_thr = thr_o;
`endif

    // Threshold register; a write takes effect from the following qualify check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_o <= '0;
        end else if (thr_we_i) begin
            thr_o <= thr_wdata_i;
        end
    end

    // Claim/complete sequencer: qualify, settle, request, then hold the claim until mret
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_id       <= '0;
            cnt          <= '0;
            irq_req_o    <= 1'b0;
            irq_id_o     <= '0;
            irq_vec_o    <= '0;
            irq_arg_o    <= '0;
            claim_mask_o <= '0;
            active_o     <= 1'b0;
`ifdef PLIC_IRQ_PREEMPT_EN
            lat_pri      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (qualify) begin
                        lat_id <= plic_id_i;
`ifdef PLIC_IRQ_PREEMPT_EN
                        lat_pri <= plic_pri_i;
`endif
                        cnt    <= CNT_LOAD;
                        state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_abort) begin
`ifdef PLIC_IRQ_PREEMPT_EN
                        if (!nest_empty) begin
                            lat_id  <= ID_W'(nest_top_ctx.id);
                            lat_pri <= nest_top_ctx.pri;
                            state   <= ACTIVE;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end else if (cnt == '0) begin
                        irq_req_o <= 1'b1;
                        irq_id_o  <= lat_id;
                        irq_vec_o <= plic_mvec_i;
                        irq_arg_o <= plic_marg_i;
                        state     <= REQ;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        irq_req_o    <= 1'b0;
                        claim_mask_o <= claim_mask_o | lat_onehot;
                        active_o     <= 1'b1;
                        state        <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (irq_done_i) begin
                        claim_mask_o <= claim_mask_o & ~lat_onehot;
`ifdef PLIC_IRQ_PREEMPT_EN
                        if (!nest_empty) begin
                            lat_id  <= ID_W'(nest_top_ctx.id);
                            lat_pri <= nest_top_ctx.pri;
                        end else begin
                            active_o <= 1'b0;
                            state    <= IDLE;
                        end
                    end else if (qualify && !nest_full) begin
                        lat_id  <= plic_id_i;
                        lat_pri <= plic_pri_i;
                        cnt     <= CNT_LOAD;
                        state   <= SETTLE;
`else
                        active_o <= 1'b0;
                        state    <= IDLE;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
